// File: rtl/bip_pkg.sv
// Shared definitions for the BIP processor: opcodes, accumulator-source
// encodings, controller states and the bundle of decode strobes.
package bip_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;

  localparam logic [1:0] SELA_RAM = 2'd0;
  localparam logic [1:0] SELA_IMM = 2'd1;
  localparam logic [1:0] SELA_ALU = 2'd2;

  localparam logic SELB_RAM = 1'b0;
  localparam logic SELB_IMM = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef struct packed {
    logic       wr_acc;
    logic       wr_ram;
    logic       rd_ram;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
  } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decode for the BIP controller; every strobe is held
// at zero unless the controller is actually executing this cycle.
module bip_decoder
  import bip_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  input  logic             valid_i,
  output ctrl_t            ctrl_o,
  output logic             halt_o
);

  always_comb begin
    ctrl_o = '0;
    halt_o = 1'b0;
    if (valid_i) begin
      case (opcode_i)
        OPC_HLT:  halt_o = 1'b1;
        OPC_STO:  ctrl_o.wr_ram = 1'b1;
        OPC_LD: begin
          ctrl_o.rd_ram = 1'b1;
          ctrl_o.sel_a  = SELA_RAM;
          ctrl_o.wr_acc = 1'b1;
        end
        OPC_LDI: begin
          ctrl_o.sel_a  = SELA_IMM;
          ctrl_o.wr_acc = 1'b1;
        end
        OPC_ADD, OPC_SUB: begin
          ctrl_o.rd_ram = 1'b1;
          ctrl_o.sel_b  = SELB_RAM;
          ctrl_o.op     = (opcode_i == OPC_SUB) ? ALU_SUB : ALU_ADD;
          ctrl_o.sel_a  = SELA_ALU;
          ctrl_o.wr_acc = 1'b1;
        end
        OPC_ADDI, OPC_SUBI: begin
          ctrl_o.sel_b  = SELB_IMM;
          ctrl_o.op     = (opcode_i == OPC_SUBI) ? ALU_SUB : ALU_ADD;
          ctrl_o.sel_a  = SELA_ALU;
          ctrl_o.wr_acc = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bip_control.sv
// BIP control unit: IDLE/RUN/HALT sequencer, program counter and operand
// sign extension; opcode decode is delegated to bip_decoder.
module bip_control
  import bip_pkg::*;
#(
  parameter int PC_WIDTH     = 11,
  parameter int DATA_WIDTH   = 16,
  parameter int OPCODE_WIDTH = 5
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_instruction,
  output logic [PC_WIDTH-1:0]   o_addr_PC,
  output logic [1:0]            o_selA,
  output logic                  o_selB,
  output logic [DATA_WIDTH-1:0] o_SIGNAL,
  output logic                  o_op,
  output logic                  o_wrACC,
  output logic                  o_wrRAM,
  output logic                  o_rdRAM,
  output logic                  o_halt
);

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [OPC_W-1:0]      opcode;
  logic                  exec_en;
  logic                  is_hlt;
  ctrl_t                 ctrl;

  assign opcode  = i_instruction[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign exec_en = (state_q == ST_RUN) && i_enable;

  bip_decoder u_decoder (
    .opcode_i (opcode),
    .valid_i  (exec_en),
    .ctrl_o   (ctrl),
    .halt_o   (is_hlt)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // PC only moves on an enabled RUN edge; the HLT edge freezes it in place.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: if (i_start) state_d = ST_RUN;
      ST_RUN: begin
        if (exec_en) begin
          if (is_hlt) state_d = ST_HALT;
          else        pc_d    = pc_q + PC_WIDTH'(1);
        end
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_addr_PC = pc_q;
  assign o_halt    = (state_q == ST_HALT);
  assign o_SIGNAL  = {{(DATA_WIDTH-PC_WIDTH){i_instruction[PC_WIDTH-1]}},
                      i_instruction[PC_WIDTH-1:0]};
  assign o_wrACC   = ctrl.wr_acc;
  assign o_wrRAM   = ctrl.wr_ram;
  assign o_rdRAM   = ctrl.rd_ram;
  assign o_selA    = ctrl.sel_a;
  assign o_selB    = ctrl.sel_b;
  assign o_op      = ctrl.op;

endmodule

// File: doc/bip_control.md
BIP_CONTROL -- requirements
Module: bip_control

Interface
REQ-001 Parameter PC_WIDTH, default 11, program-counter and operand-field width.
REQ-002 Parameter DATA_WIDTH, default 16, datapath width; instruction width is also DATA_WIDTH.
REQ-003 Parameter OPCODE_WIDTH, default 5, opcode field width (instruction[15:11]).
REQ-004 i_clock  input  1  single clock; all state updates on rising edge.
REQ-005 i_reset  input  1  asynchronous, active-low reset.
REQ-006 i_start  input  1  level; leaves IDLE when high.
REQ-007 i_enable  input  1  level; low stalls execution.
REQ-008 i_instruction  input  DATA_WIDTH  program-memory word at o_addr_PC, combinational read.
REQ-009 o_addr_PC  output  PC_WIDTH  program-memory address.
REQ-010 o_selA  output  2  ACC source: 0 RAM data, 1 o_SIGNAL, 2 ALU result.
REQ-011 o_selB  output  1  ALU B-operand mux select: 0 RAM data (i_DATA), 1 immediate (i_SIGNAL).
REQ-012 o_SIGNAL  output  DATA_WIDTH  sign-extended operand field.
REQ-013 o_op  output  1  ALU op: 0 add, 1 subtract.
REQ-014 o_wrACC, o_wrRAM, o_rdRAM  output  1 each  accumulator write, data-RAM write, data-RAM read strobes.
REQ-015 o_halt  output  1  high in HALT state.

Function
REQ-016 FSM SHALL have states IDLE, RUN, HALT.
REQ-017 IDLE SHALL go to RUN on the first edge with i_start=1; PC SHALL not change on that edge.
REQ-018 In RUN with i_enable=1, PC SHALL increment by 1 each edge unless the opcode is HLT.
REQ-019 PC SHALL wrap from 2^PC_WIDTH-1 to 0 without a flag.
REQ-020 Opcode HLT (00000) in RUN with i_enable=1 SHALL move to HALT on the next edge with PC frozen at the HLT address.
REQ-021 HALT SHALL persist until reset; i_start and i_enable SHALL be ignored there.
REQ-022 Decode SHALL be combinational from i_instruction, valid only in RUN with i_enable=1; in any other condition o_wrACC, o_wrRAM, o_rdRAM, o_selA, o_selB and o_op SHALL be 0.
REQ-023 STO 00001: o_wrRAM=1.
REQ-024 LD 00010: o_rdRAM=1, o_selA=0, o_wrACC=1.
REQ-025 LDI 00011: o_selA=1, o_wrACC=1.
REQ-026 ADD 00100: o_rdRAM=1, o_selB=0, o_op=0, o_selA=2, o_wrACC=1.
REQ-027 ADDI 00101: o_selB=1, o_op=0, o_selA=2, o_wrACC=1.
REQ-028 SUB 00110: as ADD with o_op=1; SUBI 00111: as ADDI with o_op=1.
REQ-029 Undefined opcodes (01000-11111) SHALL act as NOP: PC increments, all strobes 0.
REQ-030 o_SIGNAL SHALL always equal instruction[10:0] sign-extended from bit 10 to DATA_WIDTH, in every state.
REQ-031 i_enable=0 in RUN SHALL hold PC and state; operation resumes on the next enabled edge with no instruction lost.
REQ-032 Latency: strobes are valid in the same cycle the instruction is presented; PC advances on the closing edge.

Reset
REQ-033 Reset assertion SHALL immediately force state=IDLE, PC=0, o_halt=0, and all strobes and selects to 0, including mid-instruction and in HALT.
REQ-034 After reset release, state SHALL remain IDLE until i_start=1.

Structure
REQ-035 Opcode constants, o_selA encodings and state encodings SHALL live in shared package bip_pkg, also used by the datapath.
REQ-036 Opcode-to-strobe decode SHALL be a combinational sub-module bip_decoder; bip_control SHALL hold the FSM, PC and sign extension.

Verification
REQ-037 Reset, then i_start=1 with ROM {LDI 5, ADDI -2, HLT} -> cycle 1: o_selA=1, o_wrACC=1, o_SIGNAL=0x0005; cycle 2: o_selB=1, o_op=0, o_SIGNAL=0xFFFE; cycle 3: o_halt=1 on the next edge, o_addr_PC=2.
REQ-038 ROM {LD 3, SUB 4, STO 5} -> o_rdRAM=1 for LD and SUB; SUB gives o_selB=0, o_op=1, o_selA=2; STO gives o_wrRAM=1, o_wrACC=0.
REQ-039 i_enable=0 for 3 cycles mid-program at PC=1 -> o_addr_PC stays 1, all strobes 0; on re-enable the same instruction executes.
REQ-040 PC preloaded by NOPs (opcode 01000) to 2047 -> next edge gives o_addr_PC=0.
REQ-041 Reset asserted asynchronously mid-cycle during ADD -> strobes drop to 0 before the next edge, PC=0, state IDLE.
REQ-042 In HALT, toggle i_start and i_enable -> o_halt stays 1, o_addr_PC unchanged, strobes 0.
